// File: rtl/wb_dest_pipe.sv
// wb_dest_pipe: destination-register select (rt/rd/link) carried through DEPTH stages with stall/flush.
// Define WB_DEST_HAZARD_EN to build per-stage src_a/src_b destination comparators.
module wb_dest_pipe #(
  parameter int WIDTH    = 5,
  parameter int DEPTH    = 3,
  parameter int LINK_REG = 31
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic                   in_reg_write,
  input  logic [1:0]             in_dst_sel,
  input  logic [WIDTH-1:0]       in_rt,
  input  logic [WIDTH-1:0]       in_rd,
  input  logic                   stall,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       src_a,
  input  logic [WIDTH-1:0]       src_b,
  output logic                   wb_we,
  output logic [WIDTH-1:0]       wb_addr,
  output logic [DEPTH-1:0]       stage_we,
  output logic [DEPTH*WIDTH-1:0] stage_addr,
  output logic [DEPTH-1:0]       hazard_a,
  output logic [DEPTH-1:0]       hazard_b
);
  localparam logic [WIDTH-1:0] LINK = WIDTH'(LINK_REG);
  logic [DEPTH-1:0]            r_we;
  logic [DEPTH-1:0][WIDTH-1:0] r_addr;
  logic [WIDTH-1:0]            w_sel_addr;
  logic                        w_we;
  always_comb begin
    w_sel_addr = in_dst_sel == 2'b00 ? in_rt :
                 in_dst_sel == 2'b01 ? in_rd :
                 in_dst_sel == 2'b10 ? LINK  : '0;
    w_we = in_valid & in_reg_write & (in_dst_sel != 2'b11) & (w_sel_addr != '0);
  end
  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    logic             w_nxt_we;
    logic [WIDTH-1:0] w_nxt_addr;
    if (g == 0) begin : g_head
      assign w_nxt_we   = w_we;
      assign w_nxt_addr = w_sel_addr;
    end else begin : g_tail
      assign w_nxt_we   = r_we[g-1];
      assign w_nxt_addr = r_addr[g-1];
    end
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_we[g]   <= 1'b0;
        r_addr[g] <= '0;
      end else if (flush) begin
        r_we[g]   <= 1'b0;
        r_addr[g] <= '0;
      end else if (!stall) begin
        r_we[g]   <= w_nxt_we;
        r_addr[g] <= w_nxt_addr;
      end
    end
  end
  assign stage_we   = r_we;
  assign stage_addr = r_addr;
  assign wb_we      = r_we[DEPTH-1];
  assign wb_addr    = r_addr[DEPTH-1];
`ifdef WB_DEST_HAZARD_EN
  for (genvar h = 0; h < DEPTH; h++) begin : g_haz
    assign hazard_a[h] = r_we[h] & (r_addr[h] == src_a);
    assign hazard_b[h] = r_we[h] & (r_addr[h] == src_b);
  end
`else
  logic w_unused;
  assign w_unused = ^{src_a, src_b};
  assign hazard_a = '0;
  assign hazard_b = '0;
`endif
endmodule

// File: tb/tb_wb_dest_pipe.sv
// tb_wb_dest_pipe: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_wb_dest_pipe;
  localparam int W = 5;
  localparam int D = 3;
  typedef struct packed { logic we; logic [W-1:0] addr; } ent_t;
  logic clk = 0, rst_n = 0;
  logic in_valid = 0, in_reg_write = 0, stall = 0, flush = 0;
  logic [1:0] in_dst_sel = 0;
  logic [W-1:0] in_rt = 0, in_rd = 0, src_a = 0, src_b = 0;
  logic wb_we;
  logic [W-1:0] wb_addr;
  logic [D-1:0] stage_we, hazard_a, hazard_b;
  logic [D*W-1:0] stage_addr;
  int checks = 0, errors = 0;
  ent_t q[$];
  bit haz_en;

  wb_dest_pipe #(.WIDTH(W), .DEPTH(D), .LINK_REG(31)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_reg_write(in_reg_write),
    .in_dst_sel(in_dst_sel), .in_rt(in_rt), .in_rd(in_rd), .stall(stall), .flush(flush),
    .src_a(src_a), .src_b(src_b), .wb_we(wb_we), .wb_addr(wb_addr), .stage_we(stage_we),
    .stage_addr(stage_addr), .hazard_a(hazard_a), .hazard_b(hazard_b));

  always #5 clk = ~clk;

  function automatic ent_t decode(logic v, logic rw, logic [1:0] sel, logic [W-1:0] rt, logic [W-1:0] rd);
    ent_t e;
    e.addr = sel == 0 ? rt : sel == 1 ? rd : sel == 2 ? W'(31) : '0;
    e.we = v && rw && sel != 3 && e.addr != 0;
    return e;
  endfunction

  task automatic model_clear();
    q.delete();
    for (int i = 0; i < D; i++) q.push_back('0);
  endtask

  task automatic drive(logic v, logic rw, logic [1:0] sel, logic [W-1:0] rt, logic [W-1:0] rd, logic st, logic fl);
    in_valid = v; in_reg_write = rw; in_dst_sel = sel; in_rt = rt; in_rd = rd; stall = st; flush = fl;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    if (flush) model_clear();
    else if (!stall) begin
      q.push_front(decode(in_valid, in_reg_write, in_dst_sel, in_rt, in_rd));
      void'(q.pop_back());
    end
    #1;
  endtask

  task automatic do_reset();
    idle();
    #2 rst_n = 0;
    model_clear();
    @(posedge clk); #1 rst_n = 1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    model_clear();
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if ({wb_we, wb_addr, stage_we, stage_addr, hazard_a, hazard_b} !== '0) begin
      errors++; $display("FAIL reset_held: got we=%b addr=%0d stage_we=%b stage_addr=%h exp all 0", wb_we, wb_addr, stage_we, stage_addr);
    end
    rst_n = 1;
    tick();
    checks++;
    if ({wb_we, wb_addr, stage_we, stage_addr} !== '0) begin
      errors++; $display("FAIL reset_release: got we=%b stage_we=%b stage_addr=%h exp all 0", wb_we, stage_we, stage_addr);
    end
  endtask

  task automatic test_select();
    logic [D-1:0] exp_sw[3] = '{3'b001, 3'b010, 3'b100};
    do_reset();
    drive(1, 1, 2'b01, 5'd3, 5'd7, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      idle();
      checks++;
      if (stage_we !== exp_sw[i]) begin
        errors++; $display("FAIL select_stage_we[%0d]: got %b exp %b", i, stage_we, exp_sw[i]);
      end
      checks++;
      if (wb_we !== (i == 2)) begin
        errors++; $display("FAIL select_wb_we[%0d]: got %b exp %b", i, wb_we, i == 2);
      end
    end
    checks++;
    if (wb_addr !== 5'd7) begin
      errors++; $display("FAIL select_wb_addr: got %0d exp 7", wb_addr);
    end
    tick();
    checks++;
    if (wb_we !== 1'b0) begin
      errors++; $display("FAIL select_one_cycle: got wb_we %b exp 0", wb_we);
    end
  endtask

  task automatic test_link_reserved();
    do_reset();
    drive(1, 1, 2'b10, 5'd4, 5'd9, 0, 0);
    tick(); idle(); tick(); tick();
    checks++;
    if ({wb_we, wb_addr} !== {1'b1, 5'd31}) begin
      errors++; $display("FAIL link: got we=%b addr=%0d exp we=1 addr=31", wb_we, wb_addr);
    end
    drive(1, 1, 2'b11, 5'd4, 5'd9, 0, 0);
    tick(); idle();
    checks++;
    if ({stage_we[0], stage_addr[W-1:0]} !== '0) begin
      errors++; $display("FAIL reserved_stage0: got we=%b addr=%0d exp 0/0", stage_we[0], stage_addr[W-1:0]);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (wb_we !== 1'b0) begin
        errors++; $display("FAIL reserved_wb[%0d]: got wb_we %b exp 0", i, wb_we);
      end
    end
  endtask

  task automatic test_zero();
    do_reset();
    drive(1, 1, 2'b00, 5'd0, 5'd8, 0, 0);
    tick(); idle();
    checks++;
    if (stage_we !== '0) begin
      errors++; $display("FAIL zero_stage_we: got %b exp 000", stage_we);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (wb_we !== 1'b0) begin
        errors++; $display("FAIL zero_wb[%0d]: got wb_we %b exp 0", i, wb_we);
      end
    end
  endtask

  task automatic test_stall_flush();
    logic seen;
    do_reset();
    drive(1, 1, 2'b01, 0, 5'd5, 0, 0); tick();
    drive(1, 1, 2'b01, 0, 5'd6, 0, 0); tick();
    drive(1, 1, 2'b01, 0, 5'd9, 1, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({stage_we, stage_addr[2*W-1:0], wb_we} !== {3'b011, 5'd5, 5'd6, 1'b0}) begin
        errors++; $display("FAIL stall_hold[%0d]: got stage_we=%b addr=%h wb_we=%b exp 011 / 5,6 / 0", i, stage_we, stage_addr, wb_we);
      end
    end
    drive(1, 1, 2'b01, 0, 5'd9, 1, 1);
    tick(); idle();
    checks++;
    if (stage_we !== '0) begin
      errors++; $display("FAIL flush_over_stall: got stage_we %b exp 000", stage_we);
    end
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      seen |= wb_we;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL flush_no_write: got wb_we seen %b exp 0", seen);
    end
  endtask

  task automatic test_hazard();
    logic [D-1:0] exp_a;
    do_reset();
    drive(1, 1, 2'b01, 0, 5'd12, 0, 0); tick();
    idle(); tick();
    src_a = 5'd12; src_b = 5'd3;
    #1;
    exp_a = haz_en ? 3'b010 : 3'b000;
    checks++;
    if ({hazard_a, hazard_b} !== {exp_a, 3'b000}) begin
      errors++; $display("FAIL hazard: got a=%b b=%b exp a=%b b=000", hazard_a, hazard_b, exp_a);
    end
    src_a = 0; src_b = 0;
  endtask

  task automatic test_async_reset();
    logic seen;
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      drive(1, 1, 2'b01, 0, W'(i), 0, 0);
      tick();
    end
    idle();
    #2 rst_n = 0;
    model_clear();
    #1;
    checks++;
    if ({wb_we, wb_addr, stage_we, stage_addr} !== '0) begin
      errors++; $display("FAIL async_reset: got we=%b addr=%0d stage_we=%b stage_addr=%h exp all 0", wb_we, wb_addr, stage_we, stage_addr);
    end
    #2 rst_n = 1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      seen |= wb_we;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL async_no_write: got wb_we seen %b exp 0", seen);
    end
  endtask

  task automatic test_random();
    logic [D-1:0] ew, ha, hb;
    logic [D*W-1:0] ea;
    int bad;
    do_reset();
    bad = 0;
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
            W'($urandom_range(0, 7)), W'($urandom_range(0, 7)),
            $urandom_range(0, 5) == 0, $urandom_range(0, 15) == 0);
      src_a = W'($urandom_range(0, 7)); src_b = W'($urandom_range(0, 7));
      tick();
      for (int i = 0; i < D; i++) begin
        ew[i] = q[i].we;
        ea[i*W +: W] = q[i].addr;
        ha[i] = haz_en && q[i].we && q[i].addr == src_a;
        hb[i] = haz_en && q[i].we && q[i].addr == src_b;
      end
      checks++;
      if ({stage_we, stage_addr, wb_we, wb_addr, hazard_a, hazard_b} !== {ew, ea, q[D-1].we, q[D-1].addr, ha, hb}) begin
        errors++;
        if (bad++ < 10) $display("FAIL random[%0d]: got we=%b addr=%h ha=%b hb=%b exp we=%b addr=%h ha=%b hb=%b",
                                 n, stage_we, stage_addr, hazard_a, hazard_b, ew, ea, ha, hb);
      end
    end
  endtask

  initial begin
`ifdef WB_DEST_HAZARD_EN
    haz_en = 1;
`else
    haz_en = 0;
`endif
    test_reset();
    test_select();
    test_link_reserved();
    test_zero();
    test_stall_flush();
    test_hazard();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_dest_pipe.md
Name: wb_dest_pipe

Overview:
- Parametrised successor to the single-cycle write-register select, for the pipelined datapath.
- Selects the destination register per instruction from three sources: rt, rd, or the link register.
- Carries the destination and its write-enable through DEPTH pipeline stages, with stall and flush.
- Presents the final stage as the register-file write port; optionally reports per-stage destination matches for hazard/forwarding logic.

Parameters:
- WIDTH, 5, register-address width in bits.
- DEPTH, 3, number of pipeline stages between decode and writeback; legal range 1..8.
- LINK_REG, 31, register address written for link (jal-type) instructions.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  decode stage holds a real instruction this cycle.
- in_reg_write  input  1  instruction writes the register file.
- in_dst_sel  input  2  00 = rt, 01 = rd, 10 = LINK_REG, 11 = reserved (no write).
- in_rt  input  WIDTH  rt field.
- in_rd  input  WIDTH  rd field.
- stall  input  1  freeze all stages.
- flush  input  1  kill all in-flight entries.
- src_a  input  WIDTH  first source register of the decode-stage instruction.
- src_b  input  WIDTH  second source register of the decode-stage instruction.
- wb_we  output  1  register-file write enable (final stage).
- wb_addr  output  WIDTH  register-file write address (final stage).
- stage_we  output  DEPTH  per-stage effective write enable; bit 0 = youngest.
- stage_addr  output  DEPTH*WIDTH  per-stage destination; slice i = stage i.
- hazard_a  output  DEPTH  bit i set: stage i writes src_a.
- hazard_b  output  DEPTH  bit i set: stage i writes src_b.

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid, we and addr bits clear to 0. All outputs are 0 while reset is held and on the first edge after release.
- Select (combinational, decode side):
  - sel_addr = in_rt / in_rd / LINK_REG for in_dst_sel 00 / 01 / 10.
  - in_dst_sel = 11 gives sel_addr 0 with the write forced off.
- Effective write enable: in_valid & in_reg_write & (in_dst_sel != 11) & (sel_addr != 0). Writes to register 0 are always suppressed; an entry keeps its address but its we = 0.
- Each clock edge, in priority order:
  - flush = 1: all stages' we and valid clear to 0; addr fields are don't-care, implemented as cleared. Flush wins over stall.
  - else stall = 1: every stage holds its value.
  - else: stage 0 captures sel_addr and the effective we; stage i captures stage i-1 for i = 1..DEPTH-1.
- Latency: an entry accepted on edge k appears on wb_we/wb_addr after edge k+DEPTH-1, i.e. it is in stage DEPTH-1 for one cycle, absent stalls.
- wb_we = stage_we[DEPTH-1]; wb_addr = stage_addr slice DEPTH-1. Both are registered, with no combinational path from inputs.
- DEPTH = 1: stage 0 is the writeback stage.
- stall and flush asserted together: flush wins.
- in_valid = 0 with stall = 0: a bubble (we = 0) enters stage 0.
- Reset asserted mid-operation: in-flight entries are discarded immediately, no partial write.
- Out-of-range LINK_REG (≥ 2^WIDTH) is a configuration error; it is truncated to WIDTH bits.

Optional Feature:
- Macro: WB_DEST_HAZARD_EN.
- Defined:
  - hazard_a[i] = stage_we[i] & (stage_addr[i] == src_a); hazard_b likewise for src_b.
  - Purely combinational from registered state and the src inputs.
  - A src of 0 never matches, since we is already 0 for register 0.
- Undefined: hazard_a and hazard_b are tied to all-zero, and the comparators are not built. The ports remain present so the interface is unchanged.

Test Plan:
- Reset then select, DEPTH = 3: in_dst_sel 01, in_rd = 7, valid, reg_write on one cycle → wb_we = 1, wb_addr = 7 exactly 3 edges later for one cycle; stage_we sequence 001, 010, 100.
- Link and reserved: in_dst_sel 10 → wb_addr = 31, wb_we = 1; in_dst_sel 11 with in_rd = 9 → wb_we stays 0.
- Zero suppression: in_dst_sel 00, in_rt = 0 → the entry propagates with we = 0 through all stages; wb_we never asserts.
- Stall/flush: issue rd = 5 then rd = 6, stall 2 cycles → stage contents frozen, wb output unchanged. Then assert flush and stall together → all stage_we = 0 next edge, and 5/6 are never written.
- Hazard (WB_DEST_HAZARD_EN defined): stage 1 holds we = 1, addr 12; src_a = 12, src_b = 3 → hazard_a = 010, hazard_b = 000. Rebuilt without the macro → both 000.
- Async reset mid-flight: three valid writes in flight, pulse rst_n low between edges → all outputs go 0 immediately, no writeback occurs after release.
